// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with valid/ready handshake,
// trap/redirect steering, halt/resume and misaligned-target detection.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    input  logic             pc_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted,
    output logic             misalign_err,
    output logic [XLEN-1:0]  err_addr,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Low target bits that must be clear for a legal fetch address.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    state_t state;
    logic   tgt_aligned_c;
    logic   fire_c;

    assign tgt_aligned_c = (redirect_target & ALIGN_MASK) == '0;
    assign fire_c        = pc_valid && pc_ready;

    // State machine, PC steering, error capture and fetch counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            err_addr     <= '0;
            fetch_cnt    <= '0;
        end else begin
            misalign_err <= 1'b0;

            // A completed handshake always counts, even if the PC is redirected.
            if (fire_c) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end

            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    halted   <= 1'b0;
                end

                RUN: begin
                    if (trap_valid) begin
                        pc <= trap_vector;
                    end else if (redirect_valid && tgt_aligned_c) begin
                        pc <= redirect_target;
                    end else if (redirect_valid) begin
                        err_addr     <= redirect_target;
                        misalign_err <= 1'b1;
                        state        <= HALT;
                        pc_valid     <= 1'b0;
                        halted       <= 1'b1;
                    end else if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (fire_c) begin
                        pc <= pc + XLEN'(INC);
                    end
                end

                HALT: begin
                    if (trap_valid) begin
                        pc       <= trap_vector;
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end else begin
                        if (redirect_valid && tgt_aligned_c) begin
                            pc <= redirect_target;
                        end else if (redirect_valid) begin
                            err_addr     <= redirect_target;
                            misalign_err <= 1'b1;
                        end
                        if (resume) begin
                            state    <= RUN;
                            pc_valid <= 1'b1;
                            halted   <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen; the driver queues the expected
// outputs for each edge and a negedge monitor pops and compares them.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic [31:0] fetch_cnt;

    // Second instance for address/counter wrap.
    logic        rst_w;
    logic        ready_w;
    logic [31:0] pc_w;
    logic        valid_w;
    logic        halted_w;
    logic        mis_w;
    logic [31:0] err_w;
    logic [1:0]  cnt_w;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .halt_req       (halt_req),
        .resume         (resume),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .err_addr       (err_addr),
        .fetch_cnt      (fetch_cnt)
    );

    pc_gen #(
        .RESET_VECTOR(32'hFFFF_FFF8),
        .INC         (4),
        .CNT_W       (2)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst_w),
        .pc             (pc_w),
        .pc_valid       (valid_w),
        .pc_ready       (ready_w),
        .redirect_valid (1'b0),
        .redirect_target(32'h0),
        .trap_valid     (1'b0),
        .trap_vector    (32'h0),
        .halt_req       (1'b0),
        .resume         (1'b0),
        .halted         (halted_w),
        .misalign_err   (mis_w),
        .err_addr       (err_w),
        .fetch_cnt      (cnt_w)
    );

    typedef struct {
        int          tag;
        bit          sel;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        m;
        logic [31:0] err;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due after the most recent edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t        e;
            logic [31:0] a_pc;
            logic [31:0] a_err;
            logic [31:0] a_cnt;
            logic        a_v;
            logic        a_h;
            logic        a_m;
            e = q.pop_front();
            if (e.sel) begin
                a_pc = pc_w; a_v = valid_w; a_h = halted_w; a_m = mis_w;
                a_err = err_w; a_cnt = {30'd0, cnt_w};
            end else begin
                a_pc = pc; a_v = pc_valid; a_h = halted; a_m = misalign_err;
                a_err = err_addr; a_cnt = fetch_cnt;
            end
            n_vec++;
            if (e.tag != cyc) begin
                n_miss++;
                $display("FAIL tag: checked at cycle %0d, required cycle %0d", cyc, e.tag);
            end
            if (a_pc !== e.pc) begin
                n_miss++;
                $display("FAIL pc@%0d dut%0d: got %h, want %h", e.tag, e.sel, a_pc, e.pc);
            end
            if (a_v !== e.v) begin
                n_miss++;
                $display("FAIL pc_valid@%0d dut%0d: got %b, want %b", e.tag, e.sel, a_v, e.v);
            end
            if (a_h !== e.h) begin
                n_miss++;
                $display("FAIL halted@%0d dut%0d: got %b, want %b", e.tag, e.sel, a_h, e.h);
            end
            if (a_m !== e.m) begin
                n_miss++;
                $display("FAIL misalign_err@%0d dut%0d: got %b, want %b", e.tag, e.sel, a_m, e.m);
            end
            if (a_err !== e.err) begin
                n_miss++;
                $display("FAIL err_addr@%0d dut%0d: got %h, want %h", e.tag, e.sel, a_err, e.err);
            end
            if (a_cnt !== e.cnt) begin
                n_miss++;
                $display("FAIL fetch_cnt@%0d dut%0d: got %0d, want %0d", e.tag, e.sel, a_cnt, e.cnt);
            end
        end
    end

    // Queue the outputs expected after the next edge, then let that edge pass.
    task automatic step(input bit sel, input logic [31:0] e_pc, input logic e_v,
                        input logic e_h, input logic e_m, input logic [31:0] e_err,
                        input logic [31:0] e_cnt);
        exp_t e;
        e.tag = cyc + 1; e.sel = sel; e.pc = e_pc; e.v = e_v; e.h = e_h;
        e.m = e_m; e.err = e_err; e.cnt = e_cnt;
        q.push_back(e);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        trap_valid     = 1'b0;
        halt_req       = 1'b0;
        resume         = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_vector = '0; halt_req = 1'b0; resume = 1'b0;
        rst_w = 1'b1; ready_w = 1'b1;

        // Reset, boot cycle, sequential fetch.
        step(0, 32'h0, 0, 0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        step(0, 32'h0, 1, 0, 0, 32'h0, 0);
        step(0, 32'h4, 1, 0, 0, 32'h0, 1);
        step(0, 32'h8, 1, 0, 0, 32'h0, 2);
        step(0, 32'hC, 1, 0, 0, 32'h0, 3);
        step(0, 32'h10, 1, 0, 0, 32'h0, 4);

        // Back-pressure then redirect with a simultaneous handshake.
        pc_ready = 1'b0;
        step(0, 32'h10, 1, 0, 0, 32'h0, 4);
        step(0, 32'h10, 1, 0, 0, 32'h0, 4);
        step(0, 32'h10, 1, 0, 0, 32'h0, 4);
        pc_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
        step(0, 32'h200, 1, 0, 0, 32'h0, 5);
        step(0, 32'h204, 1, 0, 0, 32'h0, 6);

        // Trap beats redirect and halt_req.
        trap_valid = 1'b1; trap_vector = 32'h8000_0100;
        redirect_valid = 1'b1; redirect_target = 32'h400; halt_req = 1'b1;
        step(0, 32'h8000_0100, 1, 0, 0, 32'h0, 7);
        step(0, 32'h8000_0104, 1, 0, 0, 32'h0, 8);

        // Misaligned redirect: pulse, capture, halt, then resume.
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step(0, 32'h8000_0104, 0, 1, 1, 32'h102, 9);
        step(0, 32'h8000_0104, 0, 1, 0, 32'h102, 9);
        resume = 1'b1;
        step(0, 32'h8000_0104, 1, 0, 0, 32'h102, 9);

        // halt_req with a handshake in the same cycle: fetch still counts.
        halt_req = 1'b1;
        step(0, 32'h8000_0104, 0, 1, 0, 32'h102, 10);
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step(0, 32'h300, 0, 1, 0, 32'h102, 10);
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step(0, 32'h300, 0, 1, 1, 32'h102, 10);

        // Reset while halted, with a trap that must be ignored.
        rst = 1'b1; trap_valid = 1'b1; trap_vector = 32'h8000_0100;
        step(0, 32'h0, 0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        step(0, 32'h0, 1, 0, 0, 32'h0, 0);
        step(0, 32'h4, 1, 0, 0, 32'h0, 1);

        // PC and counter wrap on the second instance.
        step(1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0, 0);
        rst_w = 1'b0;
        step(1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0, 0);
        step(1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0, 1);
        step(1, 32'h0, 1, 0, 0, 32'h0, 2);
        step(1, 32'h4, 1, 0, 0, 32'h0, 3);
        step(1, 32'h8, 1, 0, 0, 32'h0, 0);

        // Drain: the monitor must have consumed everything within a bound.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
